// File: rtl/control_fsm_pkg.sv
// Shared encodings for the KGP mini-RISC control unit: opcodes, func codes,
// ALU/branch/writeback encodings, FSM states and the decoded control bundle.
package kgp_ctrl_pkg;

  localparam int OPW   = 6;
  localparam int FUNCW = 6;

  localparam logic [OPW-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPW-1:0] OP_ALUI  = 6'd1;
  localparam logic [OPW-1:0] OP_LW    = 6'd2;
  localparam logic [OPW-1:0] OP_SW    = 6'd3;
  localparam logic [OPW-1:0] OP_BR    = 6'd4;
  localparam logic [OPW-1:0] OP_HALT  = 6'd63;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_COMP = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_MAX  = 4'd9;

  localparam logic [4:0] BR_NONE = 5'd0;
  localparam logic [4:0] BR_B    = 5'd1;
  localparam logic [4:0] BR_BR   = 5'd2;
  localparam logic [4:0] BR_BLTZ = 5'd3;
  localparam logic [4:0] BR_BZ   = 5'd4;
  localparam logic [4:0] BR_BNZ  = 5'd5;
  localparam logic [4:0] BR_BL   = 5'd6;
  localparam logic [4:0] BR_BCY  = 5'd7;
  localparam logic [4:0] BR_BNCY = 5'd8;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_RS   = 2'b01;
  localparam logic [1:0] RW_RT   = 2'b10;

  localparam logic [1:0] WMUX_LINK = 2'b00;
  localparam logic [1:0] WMUX_DMEM = 2'b01;
  localparam logic [1:0] WMUX_ALU  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU  = 3'd0,
    C_LW   = 3'd1,
    C_SW   = 3'd2,
    C_BR   = 3'd3,
    C_HALT = 3'd4,
    C_ILL  = 3'd5
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [3:0] alu_op;
    logic       imm_sel;
    logic       alu_src;
    logic [4:0] br_op;
    logic [1:0] wmux;
    logic [1:0] rw;
  } ctrl_t;

endpackage

// File: rtl/control_fsm_if.sv
// Control/status bundle between the control FSM (slave side) and the
// data path / bench that drives run and the instruction fields (master side).
interface control_fsm_if #(
  parameter int OPW   = 6,
  parameter int FUNCW = 6
);
  logic             run;
  logic [OPW-1:0]   opcode_in;
  logic [FUNCW-1:0] func_in;
  logic             ir_load;
  logic             pc_en;
  logic [1:0]       reg_write;
  logic             imm_mux_ctrl;
  logic             alu_mux_ctrl;
  logic [3:0]       alu_op;
  logic             dmem_enable;
  logic             dmem_write_enable;
  logic [1:0]       reg_write_mux_ctrl;
  logic [4:0]       br_op;
  logic             halted;
  logic             illegal;
  logic [2:0]       state_out;

  modport master (
    output run, opcode_in, func_in,
    input  ir_load, pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
           dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op,
           halted, illegal, state_out
  );

  modport slave (
    input  run, opcode_in, func_in,
    output ir_load, pc_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
           dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op,
           halted, illegal, state_out
  );
endinterface

// File: rtl/control_fsm_decode.sv
// Pure combinational instruction decoder: opcode/func -> control bundle,
// with an illegal flag for undecodable encodings.
module ctrl_decode
  import kgp_ctrl_pkg::*;
#(
  parameter int OPW   = 6,
  parameter int FUNCW = 6
) (
  input  logic [OPW-1:0]   opcode,
  input  logic [FUNCW-1:0] func,
  output ctrl_t            ctrl,
  output logic             illegal
);

  always_comb begin
    ctrl    = '0;
    ctrl.cls = C_ILL;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ALUI: begin
        ctrl.cls     = C_ALU;
        ctrl.alu_op  = func[3:0];
        ctrl.imm_sel = (opcode == OP_ALUI);
        ctrl.alu_src = (opcode == OP_ALUI);
        ctrl.wmux    = WMUX_ALU;
        ctrl.rw      = RW_RS;
        if (func > FUNCW'(ALU_MAX)) begin
          ctrl.cls = C_ILL;
          illegal  = 1'b1;
        end
      end
      OP_LW: begin
        ctrl.cls     = C_LW;
        ctrl.alu_op  = ALU_ADD;
        ctrl.imm_sel = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.wmux    = WMUX_DMEM;
        ctrl.rw      = RW_RT;
      end
      OP_SW: begin
        ctrl.cls     = C_SW;
        ctrl.alu_op  = ALU_ADD;
        ctrl.imm_sel = 1'b1;
        ctrl.alu_src = 1'b1;
      end
      OP_BR: begin
        ctrl.cls   = C_BR;
        ctrl.br_op = func[4:0];
        // bl links pc+4 into rs while the branch itself resolves
        if (func[4:0] == BR_BL) begin
          ctrl.rw   = RW_RS;
          ctrl.wmux = WMUX_LINK;
        end
        if (func == '0 || func > FUNCW'(BR_BNCY)) begin
          ctrl.cls = C_ILL;
          illegal  = 1'b1;
        end
      end
      OP_HALT: ctrl.cls = C_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM for the KGP mini-RISC core. Sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB and gates all strobes.
module control_fsm
  import kgp_ctrl_pkg::*;
#(
  parameter int OPW             = kgp_ctrl_pkg::OPW,
  parameter int FUNCW           = kgp_ctrl_pkg::FUNCW,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic         clk,
  input logic         rst,
  control_fsm_if.slave bus
);

  state_t state, state_nx;
  ctrl_t  dec, dec_q;
  logic   dec_ill;
  logic   illegal_q, illegal_set;

  logic       ir_load, pc_en, dmem_en, dmem_we, halted, drive;
  logic [1:0] rw;

  ctrl_decode #(.OPW(OPW), .FUNCW(FUNCW)) u_dec (
    .opcode  (bus.opcode_in),
    .func    (bus.func_in),
    .ctrl    (dec),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dec_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) dec_q <= dec;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    illegal_set = 1'b0;
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    rw          = RW_NONE;
    dmem_en     = 1'b0;
    dmem_we     = 1'b0;
    halted      = 1'b0;
    drive       = 1'b0;
    case (state)
      S_IDLE: if (bus.run) state_nx = S_FETCH;
      S_FETCH: begin
        ir_load  = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (dec.cls == C_HALT) begin
          state_nx = S_HALT;
        end else if (dec_ill) begin
          illegal_set = 1'b1;
          if (HALT_ON_ILLEGAL) begin
            state_nx = S_HALT;
          end else begin
            pc_en    = 1'b1;
            state_nx = S_FETCH;
          end
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        drive = 1'b1;
        case (dec_q.cls)
          C_BR: begin
            pc_en    = 1'b1;
            rw       = dec_q.rw;
            state_nx = S_FETCH;
          end
          C_LW, C_SW: state_nx = S_MEM;
          default:    state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        drive   = 1'b1;
        dmem_en = 1'b1;
        if (dec_q.cls == C_SW) begin
          dmem_we  = 1'b1;
          pc_en    = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        drive    = 1'b1;
        rw       = dec_q.rw;
        pc_en    = 1'b1;
        dmem_en  = (dec_q.cls == C_LW);
        state_nx = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  // Reset masks every output in the same cycle so a mid-instruction
  // reset can never leak a strobe.
  logic live, hold;
  assign live = ~rst;
  assign hold = drive & ~rst;

  assign bus.ir_load            = ir_load & live;
  assign bus.pc_en              = pc_en & live;
  assign bus.reg_write          = live ? rw : RW_NONE;
  assign bus.dmem_enable        = dmem_en & live;
  assign bus.dmem_write_enable  = dmem_we & live;
  assign bus.halted             = halted & live;
  assign bus.illegal            = illegal_q & live;
  assign bus.imm_mux_ctrl       = hold & dec_q.imm_sel;
  assign bus.alu_mux_ctrl       = hold & dec_q.alu_src;
  assign bus.alu_op             = hold ? dec_q.alu_op : 4'd0;
  assign bus.reg_write_mux_ctrl = hold ? dec_q.wmux : 2'b00;
  assign bus.br_op              = hold ? dec_q.br_op : 5'd0;
  assign bus.state_out          = live ? state : S_IDLE;

endmodule
